alu_muldiv_seq: RTL

Multi-cycle sequencer that performs unsigned 32x32 multiply and 32/32 divide by driving the shared 32-bit ALU one operation per cycle. It sits beside the ALU in the datapath and sources the ALU's a, b and control lines while busy. Products and quotient/remainder are assembled in internal shift registers and held on hi/lo until the next accepted start.

---
 rtl/alu_muldiv_seq.sv | 127 ++++++++++++
 1 files changed

// File: rtl/alu_muldiv_seq.sv
// Sequencer for unsigned 32x32 multiply and 32/32 divide, one shared-ALU add or subtract per cycle.
// Results are held on hi/lo and dz until the next accepted start.
module alu_muldiv_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic        busy,
    output logic        done,
    output logic        dz,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_ctl,
    input  logic [31:0] alu_sum
);

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic        op_r;
    logic [31:0] acc;   // multiply: P_hi, divide: R
    logic [31:0] low;   // multiply: P_lo, divide: Q
    logic [31:0] opr;   // multiply: M,    divide: D

    logic        carry;
    logic        borrow;
    logic        take;
    logic [31:0] nxt_acc;
    logic [31:0] nxt_low;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_ctl = ALU_ADD;
        if (state == RUN) begin
            alu_b = opr;
            if (op_r) begin
                alu_a   = {acc[30:0], low[31]};
                alu_ctl = ALU_SUB;
            end else begin
                alu_a   = acc;
            end
        end
    end

    // Carry and borrow are recovered from the operand and result sign bits; the ALU exposes neither.
    always_comb begin
        carry  = (alu_a[31] & alu_b[31]) | ((alu_a[31] | alu_b[31]) & ~alu_sum[31]);
        borrow = (~alu_a[31] & alu_b[31]) | (~(alu_a[31] ^ alu_b[31]) & alu_sum[31]);
        take   = acc[31] | ~borrow;
        if (op_r) begin
            nxt_acc = take ? alu_sum : {acc[30:0], low[31]};
            nxt_low = {low[30:0], take};
        end else if (low[0]) begin
            nxt_acc = {carry, alu_sum[31:1]};
            nxt_low = {alu_sum[0], low[31:1]};
        end else begin
            nxt_acc = {1'b0, acc[31:1]};
            nxt_low = {acc[0], low[31:1]};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            dz    <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            op_r  <= 1'b0;
            acc   <= '0;
            low   <= '0;
            opr   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r <= op;
                        if (op && (opb == 32'd0)) begin
                            hi    <= opa;
                            lo    <= '1;
                            dz    <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            acc   <= '0;
                            low   <= op ? opa : opb;
                            opr   <= op ? opb : opa;
                            dz    <= 1'b0;
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc <= nxt_acc;
                    low <= nxt_low;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        hi    <= nxt_acc;
                        lo    <= nxt_low;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
